// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory among NREQ requesters.
// One access in flight at a time: IDLE (accept) -> ACCESS (drive memory) -> RESP (respond).
module mem_port_arbiter #(
  parameter int unsigned NREQ   = 3,
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NREQ-1:0]        req_valid_i,
  output logic [NREQ-1:0]        req_ready_o,
  input  logic [NREQ-1:0]        req_we_i,
  input  logic [NREQ*ADDR_W-1:0] req_addr_i,
  input  logic [NREQ*DATA_W-1:0] req_mask_i,
  input  logic [NREQ*DATA_W-1:0] req_wdata_i,
  output logic [NREQ-1:0]        rsp_valid_o,
  output logic [DATA_W-1:0]      rsp_rdata_o,
  output logic [ADDR_W-1:0]      mem_addr_o,
  output logic [DATA_W-1:0]      mem_mask_o,
  output logic                   mem_wf_o,
  output logic [DATA_W-1:0]      mem_w_o,
  input  logic [DATA_W-1:0]      mem_v_i,
  output logic                   busy_o
);

  localparam int unsigned IdxW = $clog2(NREQ);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StResp   = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [IdxW-1:0]     last_grant_q, last_grant_d;
  logic [IdxW-1:0]     grant_q, grant_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   mask_q, mask_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;

  logic                win_found;
  logic [IdxW-1:0]     win_idx;
  int unsigned         win_int;

  // Search starts one past the last grant so every requester gets a turn.
  always_comb begin
    int unsigned cand;
    win_found = 1'b0;
    win_idx   = '0;
    win_int   = 0;
    cand      = 0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = (int'(last_grant_q) + k) % NREQ;
      if (!win_found && req_valid_i[cand]) begin
        win_found = 1'b1;
        win_int   = cand;
        win_idx   = IdxW'(cand);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    we_d         = we_q;
    addr_d       = addr_q;
    mask_d       = mask_q;
    wdata_d      = wdata_q;
    unique case (state_q)
      StIdle: begin
        if (win_found) begin
          // Only the winner's slice is selected, so X on losers cannot propagate.
          we_d         = req_we_i[win_int];
          addr_d       = req_addr_i[win_int*ADDR_W +: ADDR_W];
          mask_d       = req_mask_i[win_int*DATA_W +: DATA_W];
          wdata_d      = req_wdata_i[win_int*DATA_W +: DATA_W];
          grant_d      = win_idx;
          last_grant_d = win_idx;
          state_d      = StAccess;
        end
      end
      StAccess: state_d = StResp;
      StResp:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      last_grant_q <= IdxW'(NREQ - 1);
      grant_q      <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      mask_q       <= '0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      mask_q       <= mask_d;
      wdata_q      <= wdata_d;
    end
  end

  // Outputs decode from state alone, so asserting reset clears them without waiting for a clock.
  always_comb begin
    req_ready_o = '0;
    rsp_valid_o = '0;
    rsp_rdata_o = '0;
    mem_addr_o  = '0;
    mem_mask_o  = '0;
    mem_w_o     = '0;
    mem_wf_o    = 1'b0;
    busy_o      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (rst_ni && win_found) begin
          req_ready_o[win_int] = 1'b1;
        end
      end
      StAccess: begin
        busy_o     = 1'b1;
        mem_addr_o = addr_q;
        mem_mask_o = mask_q;
        mem_w_o    = wdata_q;
        mem_wf_o   = we_q;
      end
      StResp: begin
        busy_o               = 1'b1;
        rsp_valid_o[grant_q] = 1'b1;
        rsp_rdata_o          = we_q ? '0 : mem_v_i;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a registered single-port memory model.
module tb_mem_port_arbiter;

  localparam int unsigned NREQ   = 3;
  localparam int unsigned ADDR_W = 12;
  localparam int unsigned DATA_W = 32;

  logic                   clk;
  logic                   rst_n;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ-1:0]        req_we;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ*DATA_W-1:0] req_mask;
  logic [NREQ*DATA_W-1:0] req_wdata;
  logic [NREQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]      rsp_rdata;
  logic [ADDR_W-1:0]      mem_addr;
  logic [DATA_W-1:0]      mem_mask;
  logic                   mem_wf;
  logic [DATA_W-1:0]      mem_w;
  logic [DATA_W-1:0]      mem_v;
  logic                   busy;

  logic [DATA_W-1:0]      mem [1024];

  int n_checks = 0;
  int n_fail   = 0;

  mem_port_arbiter #(
    .NREQ  (NREQ),
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .req_valid_i(req_valid),
    .req_ready_o(req_ready),
    .req_we_i   (req_we),
    .req_addr_i (req_addr),
    .req_mask_i (req_mask),
    .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid),
    .rsp_rdata_o(rsp_rdata),
    .mem_addr_o (mem_addr),
    .mem_mask_o (mem_mask),
    .mem_wf_o   (mem_wf),
    .mem_w_o    (mem_w),
    .mem_v_i    (mem_v),
    .busy_o     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_wf) begin
      mem[mem_addr[ADDR_W-1:2]] <= (mem[mem_addr[ADDR_W-1:2]] & ~mem_mask) | (mem_w & mem_mask);
    end
    mem_v <= mem[mem_addr[ADDR_W-1:2]];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int i, input logic we, input logic [ADDR_W-1:0] addr,
                         input logic [DATA_W-1:0] mask, input logic [DATA_W-1:0] wdata);
    req_we[i]                      = we;
    req_addr[i*ADDR_W +: ADDR_W]   = addr;
    req_mask[i*DATA_W +: DATA_W]   = mask;
    req_wdata[i*DATA_W +: DATA_W]  = wdata;
  endtask

  // One full IDLE/ACCESS/RESP sequence; req_valid is held for all three cycles.
  task automatic access(input string tag, input logic [NREQ-1:0] v, input int w, input logic we,
                        input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] rdata);
    @(negedge clk);
    req_valid = v;
    #1;
    check({tag, " ready"}, 64'(req_ready), 64'(1 << w));
    check({tag, " idle busy"}, 64'(busy), 64'd0);
    check({tag, " idle rsp"}, 64'(rsp_valid), 64'd0);
    @(negedge clk);
    #1;
    check({tag, " acc busy"}, 64'(busy), 64'd1);
    check({tag, " acc ready"}, 64'(req_ready), 64'd0);
    check({tag, " acc addr"}, 64'(mem_addr), 64'(addr));
    check({tag, " acc wf"}, 64'(mem_wf), 64'(we));
    check({tag, " acc rsp"}, 64'(rsp_valid), 64'd0);
    @(negedge clk);
    #1;
    check({tag, " rsp valid"}, 64'(rsp_valid), 64'(1 << w));
    check({tag, " rsp rdata"}, 64'(rsp_rdata), 64'(rdata));
    check({tag, " rsp wf"}, 64'(mem_wf), 64'd0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    mem[12'h010 >> 2] = 32'hDEADBEEF;
    mem[12'h024 >> 2] = 32'h11112222;
    mem[12'h030 >> 2] = 32'h33334444;
    rst_n     = 1'b0;
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_mask  = '0;
    req_wdata = '0;
    set_req(0, 1'b0, 12'h010, 32'hFFFFFFFF, 32'h0);
    set_req(1, 1'b0, 12'h024, 32'hFFFFFFFF, 32'h0);
    set_req(2, 1'b0, 12'h030, 32'hFFFFFFFF, 32'h0);
    #2;
    req_valid = 3'b111;
    #1;
    check("reset ready", 64'(req_ready), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset rsp", 64'(rsp_valid), 64'd0);
    check("reset wf", 64'(mem_wf), 64'd0);
    check("reset addr", 64'(mem_addr), 64'd0);
    check("reset rdata", 64'(rsp_rdata), 64'd0);
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;

    // Single read.
    access("t1", 3'b001, 0, 1'b0, 12'h010, 32'hDEADBEEF);
    req_valid = '0;

    // Write by requester 1 then read back by requester 0.
    set_req(1, 1'b1, 12'h020, 32'hFFFFFFFF, 32'h12345678);
    @(negedge clk);
    req_valid = 3'b010;
    #1;
    check("t2w ready", 64'(req_ready), 64'b010);
    @(negedge clk);
    req_valid = '0;
    #1;
    check("t2w wf", 64'(mem_wf), 64'd1);
    check("t2w addr", 64'(mem_addr), 64'h020);
    check("t2w data", 64'(mem_w), 64'h12345678);
    check("t2w mask", 64'(mem_mask), 64'hFFFFFFFF);
    @(negedge clk);
    #1;
    check("t2w wf off", 64'(mem_wf), 64'd0);
    check("t2w rsp", 64'(rsp_valid), 64'b010);
    check("t2w rdata", 64'(rsp_rdata), 64'd0);
    set_req(0, 1'b0, 12'h020, 32'hFFFFFFFF, 32'h0);
    access("t2r", 3'b001, 0, 1'b0, 12'h020, 32'h12345678);
    req_valid = '0;

    // All three valid continuously from reset: 0,1,2,0,1,2.
    @(negedge clk);
    rst_n = 1'b0;
    set_req(0, 1'b0, 12'h010, 32'hFFFFFFFF, 32'h0);
    set_req(1, 1'b0, 12'h024, 32'hFFFFFFFF, 32'h0);
    #1;
    rst_n = 1'b1;
    for (int r = 0; r < 2; r++) begin
      access("t3g0", 3'b111, 0, 1'b0, 12'h010, 32'hDEADBEEF);
      access("t3g1", 3'b111, 1, 1'b0, 12'h024, 32'h11112222);
      access("t3g2", 3'b111, 2, 1'b0, 12'h030, 32'h33334444);
    end
    req_valid = '0;

    // With last_grant=0, requester 2 beats 0 and idle 1 is skipped.
    access("t4a", 3'b001, 0, 1'b0, 12'h010, 32'hDEADBEEF);
    access("t4b", 3'b101, 2, 1'b0, 12'h030, 32'h33334444);
    access("t4c", 3'b101, 0, 1'b0, 12'h010, 32'hDEADBEEF);
    req_valid = '0;

    // Reset asserted in ACCESS of a write (last_grant=0 beforehand).
    set_req(0, 1'b1, 12'h040, 32'hFFFFFFFF, 32'hCAFEF00D);
    @(negedge clk);
    req_valid = 3'b001;
    @(negedge clk);
    req_valid = 3'b111;
    #1;
    check("t5 wf before", 64'(mem_wf), 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("t5 wf drop", 64'(mem_wf), 64'd0);
    check("t5 busy", 64'(busy), 64'd0);
    check("t5 ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    check("t5 busy held", 64'(busy), 64'd0);
    check("t5 rsp held", 64'(rsp_valid), 64'd0);
    check("t5 no write", 64'(mem[12'h040 >> 2]), 64'd0);
    rst_n = 1'b1;
    #1;
    check("t5 winner", 64'(req_ready), 64'b001);
    req_valid = '0;
    @(negedge clk);

    // Requester 2 pulses valid only while busy.
    @(negedge clk);
    req_valid = 3'b010;
    #1;
    check("t6 ready1", 64'(req_ready), 64'b010);
    @(negedge clk);
    req_valid = 3'b100;
    #1;
    check("t6 busy ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    req_valid = '0;
    #1;
    check("t6 rsp1", 64'(rsp_valid), 64'b010);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      check("t6 no rsp", 64'(rsp_valid), 64'd0);
      check("t6 idle", 64'(busy), 64'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
